// File: rtl/seg_scan_ctrl.sv
// Multiplexed seven-segment scan controller: prescaled digit scan, double-buffered
// data load, per-digit blank/blink/dp and leading-zero suppression on active-low SEG/AN.
module seg_scan_ctrl #(
  parameter int unsigned NUM_DIGITS   = 8,
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  input  logic                    lz_en,
  output logic                    pending,
  output logic                    frame_tick,
  output logic [7:0]              SEG,
  output logic [NUM_DIGITS-1:0]   AN
);

  localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int unsigned PRE_W = $clog2(SCAN_DIV);
  localparam int unsigned BLK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);
  localparam logic [BLK_W-1:0] BLK_LAST = BLK_W'(BLINK_FRAMES - 1);

  typedef logic [NUM_DIGITS-1:0][3:0] nib_arr_t;

  logic [PRE_W-1:0]      r_presc;
  logic [IDX_W-1:0]      r_idx;
  nib_arr_t              r_shown;
  nib_arr_t              r_pend_data;
  logic [NUM_DIGITS-1:0] r_shown_dp;
  logic [NUM_DIGITS-1:0] r_pend_dp;
  logic                  r_pending;
  logic [BLK_W-1:0]      r_blink_cnt;
  logic                  r_phase;
  logic                  r_frame_tick;
  logic [7:0]            r_seg;
  logic [NUM_DIGITS-1:0] r_an;

  logic                  w_tick;
  logic                  w_wrap;
  logic [NUM_DIGITS-1:0] w_lz;
  logic [7:0]            w_code;
  logic                  w_dp;
  logic                  w_dark;

  // Digit k is a leading zero when it and every more-significant nibble are zero.
  function automatic logic [NUM_DIGITS-1:0] lz_mask(input nib_arr_t d);
    logic run;
    run     = 1'b1;
    lz_mask = '0;
    for (int k = NUM_DIGITS - 1; k >= 1; k--) begin
      run        = run & (d[k] == 4'h0);
      lz_mask[k] = run;
    end
  endfunction

  function automatic logic [7:0] hex_code(input logic [3:0] n);
    case (n)
      4'h0: hex_code = 8'hC0;
      4'h1: hex_code = 8'hF9;
      4'h2: hex_code = 8'hA4;
      4'h3: hex_code = 8'hB0;
      4'h4: hex_code = 8'h99;
      4'h5: hex_code = 8'h92;
      4'h6: hex_code = 8'h82;
      4'h7: hex_code = 8'hF8;
      4'h8: hex_code = 8'h80;
      4'h9: hex_code = 8'h90;
      4'hA: hex_code = 8'h88;
      4'hB: hex_code = 8'h83;
      4'hC: hex_code = 8'hC6;
      4'hD: hex_code = 8'hA1;
      4'hE: hex_code = 8'h86;
      default: hex_code = 8'h8E;
    endcase
  endfunction

  assign w_tick = (r_presc == PRE_LAST);
  assign w_wrap = w_tick && (r_idx == IDX_LAST);

  always_comb begin
    w_lz   = lz_en ? lz_mask(r_shown) : '0;
    w_code = hex_code(r_shown[r_idx]);
    w_dp   = r_shown_dp[r_idx];
    w_dark = blank_mask[r_idx] | (blink_mask[r_idx] & r_phase) | w_lz[r_idx];
  end

  // Slot prescaler and digit index.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_presc <= '0;
      r_idx   <= '0;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PRE_W'(1);
      if (w_tick) begin
        r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + IDX_W'(1);
      end
    end
  end

  // Double buffer: a load coinciding with a wrap goes straight to the shown copy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_shown     <= '0;
      r_shown_dp  <= '0;
      r_pend_data <= '0;
      r_pend_dp   <= '0;
      r_pending   <= 1'b0;
    end else begin
      if (load) begin
        r_pend_data <= data_in;
        r_pend_dp   <= dp_in;
      end
      if (w_wrap) begin
        if (load) begin
          r_shown    <= data_in;
          r_shown_dp <= dp_in;
        end else if (r_pending) begin
          r_shown    <= r_pend_data;
          r_shown_dp <= r_pend_dp;
        end
        r_pending <= 1'b0;
      end else if (load) begin
        r_pending <= 1'b1;
      end
    end
  end

  // Blink phase toggles every BLINK_FRAMES full frames.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_blink_cnt <= '0;
      r_phase     <= 1'b0;
    end else if (w_wrap) begin
      if (r_blink_cnt == BLK_LAST) begin
        r_blink_cnt <= '0;
        r_phase     <= ~r_phase;
      end else begin
        r_blink_cnt <= r_blink_cnt + BLK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_frame_tick <= 1'b0;
      r_seg        <= 8'hFF;
      r_an         <= '1;
    end else begin
      r_frame_tick <= w_wrap;
      r_seg        <= w_dark ? 8'hFF : {w_code[7] & ~w_dp, w_code[6:0]};
      r_an         <= w_dark ? '1 : ~(NUM_DIGITS'(1) << r_idx);
    end
  end

  assign pending    = r_pending;
  assign frame_tick = r_frame_tick;
  assign SEG        = r_seg;
  assign AN         = r_an;

endmodule
